// File: rtl/axi_lite_mem_arbiter.sv
// rtl/axi_lite_mem_arbiter.sv - AXI4-Lite arbiter: IF/LS share reads, LS/LD share writes, one memory slave.
// Optional conflict counters are built when AXI_ARB_STATS_EN is defined.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif

module axi_lite_mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          IF_ARVALID,
  output logic                          IF_ARREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]    IF_ARADDR,
  input  logic [2:0]                    IF_ARPROT,
  output logic                          IF_RVALID,
  input  logic                          IF_RREADY,
  output logic [`AXI_DATA_WIDTH-1:0]    IF_RDATA,
  output logic [1:0]                    IF_RRESP,
  input  logic                          LS_ARVALID,
  output logic                          LS_ARREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]    LS_ARADDR,
  input  logic [2:0]                    LS_ARPROT,
  output logic                          LS_RVALID,
  input  logic                          LS_RREADY,
  output logic [`AXI_DATA_WIDTH-1:0]    LS_RDATA,
  output logic [1:0]                    LS_RRESP,
  input  logic                          LS_AWVALID,
  output logic                          LS_AWREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]    LS_AWADDR,
  input  logic [2:0]                    LS_AWPROT,
  input  logic                          LS_WVALID,
  output logic                          LS_WREADY,
  input  logic [`AXI_DATA_WIDTH-1:0]    LS_WDATA,
  input  logic [`AXI_STROBE_WIDTH-1:0]  LS_WSTRB,
  output logic                          LS_BVALID,
  input  logic                          LS_BREADY,
  output logic [1:0]                    LS_BRESP,
  input  logic                          LD_AWVALID,
  output logic                          LD_AWREADY,
  input  logic [`AXI_ADDR_WIDTH-1:0]    LD_AWADDR,
  input  logic [2:0]                    LD_AWPROT,
  input  logic                          LD_WVALID,
  output logic                          LD_WREADY,
  input  logic [`AXI_DATA_WIDTH-1:0]    LD_WDATA,
  input  logic [`AXI_STROBE_WIDTH-1:0]  LD_WSTRB,
  output logic                          LD_BVALID,
  input  logic                          LD_BREADY,
  output logic [1:0]                    LD_BRESP,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [`AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [`AXI_DATA_WIDTH-1:0]    M_AXI_WDATA,
  output logic [`AXI_STROBE_WIDTH-1:0]  M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [`AXI_ADDR_WIDTH-1:0]    M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [`AXI_DATA_WIDTH-1:0]    M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [31:0]                   RD_CONFLICTS,
  output logic [31:0]                   WR_CONFLICTS
`endif
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  // Owner: read 0=IF 1=LS, write 0=LS 1=LD. Prio names the tie winner in round-robin mode.
  logic rd_own_q, rd_own_d, rd_prio_q, rd_prio_d;
  logic wr_own_q, wr_own_d, wr_prio_q, wr_prio_d;
  logic wr_wvalid;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_state_q <= R_IDLE;
      rd_own_q   <= 1'b0;
      rd_prio_q  <= 1'b0;
      wr_state_q <= W_IDLE;
      wr_own_q   <= 1'b0;
      wr_prio_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_own_q   <= rd_own_d;
      rd_prio_q  <= rd_prio_d;
      wr_state_q <= wr_state_d;
      wr_own_q   <= wr_own_d;
      wr_prio_q  <= wr_prio_d;
    end
  end

  // The pointer moves only when a tie is resolved, so a lone grant never costs the other master its turn.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_own_d      = rd_own_q;
    rd_prio_d     = rd_prio_q;
    IF_ARREADY    = 1'b0;
    LS_ARREADY    = 1'b0;
    IF_RVALID     = 1'b0;
    LS_RVALID     = 1'b0;
    IF_RDATA      = '0;
    LS_RDATA      = '0;
    IF_RRESP      = 2'b00;
    LS_RRESP      = 2'b00;
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARPROT  = 3'b000;
    M_AXI_RREADY  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (IF_ARVALID || LS_ARVALID) begin
          rd_state_d = R_ADDR;
          if (IF_ARVALID && LS_ARVALID) begin
            rd_own_d  = (FIXED_PRIO != 0) ? 1'b1 : rd_prio_q;
            rd_prio_d = ~rd_own_d;
          end else begin
            rd_own_d = LS_ARVALID;
          end
        end
      end
      R_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = rd_own_q ? LS_ARADDR : IF_ARADDR;
        M_AXI_ARPROT  = rd_own_q ? LS_ARPROT : IF_ARPROT;
        IF_ARREADY    = ~rd_own_q & M_AXI_ARREADY;
        LS_ARREADY    = rd_own_q & M_AXI_ARREADY;
        if (M_AXI_ARREADY) rd_state_d = R_DATA;
      end
      R_DATA: begin
        M_AXI_RREADY = rd_own_q ? LS_RREADY : IF_RREADY;
        if (rd_own_q) begin
          LS_RVALID = M_AXI_RVALID;
          LS_RDATA  = M_AXI_RDATA;
          LS_RRESP  = M_AXI_RRESP;
        end else begin
          IF_RVALID = M_AXI_RVALID;
          IF_RDATA  = M_AXI_RDATA;
          IF_RRESP  = M_AXI_RRESP;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_own_d      = wr_own_q;
    wr_prio_d     = wr_prio_q;
    wr_wvalid     = wr_own_q ? LD_WVALID : LS_WVALID;
    LS_AWREADY    = 1'b0;
    LD_AWREADY    = 1'b0;
    LS_WREADY     = 1'b0;
    LD_WREADY     = 1'b0;
    LS_BVALID     = 1'b0;
    LD_BVALID     = 1'b0;
    LS_BRESP      = 2'b00;
    LD_BRESP      = 2'b00;
    M_AXI_AWVALID = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_BREADY  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (LS_AWVALID || LD_AWVALID) begin
          wr_state_d = W_ADDR;
          if (LS_AWVALID && LD_AWVALID) begin
            wr_own_d  = (FIXED_PRIO != 0) ? 1'b1 : wr_prio_q;
            wr_prio_d = ~wr_own_d;
          end else begin
            wr_own_d = LD_AWVALID;
          end
        end
      end
      W_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        M_AXI_AWADDR  = wr_own_q ? LD_AWADDR : LS_AWADDR;
        M_AXI_AWPROT  = wr_own_q ? LD_AWPROT : LS_AWPROT;
        LS_AWREADY    = ~wr_own_q & M_AXI_AWREADY;
        LD_AWREADY    = wr_own_q & M_AXI_AWREADY;
        if (M_AXI_AWREADY) wr_state_d = W_DATA;
      end
      W_DATA: begin
        M_AXI_WVALID = wr_wvalid;
        M_AXI_WDATA  = wr_own_q ? LD_WDATA : LS_WDATA;
        M_AXI_WSTRB  = wr_own_q ? LD_WSTRB : LS_WSTRB;
        LS_WREADY    = ~wr_own_q & M_AXI_WREADY;
        LD_WREADY    = wr_own_q & M_AXI_WREADY;
        if (wr_wvalid && M_AXI_WREADY) wr_state_d = W_RESP;
      end
      W_RESP: begin
        M_AXI_BREADY = wr_own_q ? LD_BREADY : LS_BREADY;
        if (wr_own_q) begin
          LD_BVALID = M_AXI_BVALID;
          LD_BRESP  = M_AXI_BRESP;
        end else begin
          LS_BVALID = M_AXI_BVALID;
          LS_BRESP  = M_AXI_BRESP;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

`ifdef AXI_ARB_STATS_EN
  logic [31:0] rd_conf_q, wr_conf_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_conf_q <= 32'd0;
      wr_conf_q <= 32'd0;
    end else begin
      if (rd_state_q == R_IDLE && IF_ARVALID && LS_ARVALID) rd_conf_q <= rd_conf_q + 32'd1;
      if (wr_state_q == W_IDLE && LS_AWVALID && LD_AWVALID) wr_conf_q <= wr_conf_q + 32'd1;
    end
  end

  assign RD_CONFLICTS = rd_conf_q;
  assign WR_CONFLICTS = wr_conf_q;
`else
  // Conflict counters are not built in this configuration.
`endif

endmodule
